alu32_addsub_seq: RTL and testbench

Sequential 32-bit add/subtract controller that time-multiplexes a single external 16-bit carry-lookahead adder slice over two cycles. Sits directly upstream of the 16-bit adder: it latches a 32-bit operand pair, drives the low halves, then the high halves with the captured inter-half carry, and assembles the 32-bit result plus NZCV flags. Upstream and downstream sides each use a valid/ready handshake.

---
 rtl/alu32_addsub_seq_if.sv | 36 +++
 rtl/alu32_addsub_seq.sv | 149 ++++++++++++++
 tb/tb_alu32_addsub_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu32_addsub_seq_if.sv
// Handshake and adder-slice bus for alu32_addsub_seq.
// slave = controller side, master = producer/consumer plus external 16-bit adder.
interface alu32_addsub_seq_if;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned HALF  = 16;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic [HALF-1:0]  add_a;
  logic [HALF-1:0]  add_b;
  logic             add_c0;
  logic [HALF-1:0]  add_sum;
  logic             add_c16;

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready, add_sum, add_c16,
    output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v,
           add_a, add_b, add_c0
  );

  modport master (
    output in_valid, op_a, op_b, sub, out_ready, add_sum, add_c16,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v,
           add_a, add_b, add_c0
  );
endinterface

// File: rtl/alu32_addsub_seq.sv
// 32-bit add/sub controller sharing one external 16-bit adder slice over two cycles.
// Optional macro ADDSUB_SAT_EN: saturate the result on signed overflow.
module alu32_addsub_seq (
  input  logic                  clk,
  input  logic                  rst,
  alu32_addsub_seq_if.slave     bus
);
  localparam int unsigned WIDTH = 32;
  localparam int unsigned HALF  = 16;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e            state_q, state_d;
  logic [HALF-1:0]   ra_hi_q, ra_hi_d;
  logic [HALF-1:0]   rb_hi_q, rb_hi_d;
  logic [HALF-1:0]   lo_q, lo_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_v_q, flag_v_d;
  logic [HALF-1:0]   add_a_q, add_a_d;
  logic [HALF-1:0]   add_b_q, add_b_d;
  logic              add_c0_q, add_c0_d;

  logic [WIDTH-1:0]  op_b_eff;
  logic [WIDTH-1:0]  raw_sum;
  logic              raw_v;
  logic [WIDTH-1:0]  fin_sum;

  assign op_b_eff = bus.sub ? ~bus.op_b : bus.op_b;
  assign raw_sum  = {bus.add_sum, lo_q};
  assign raw_v    = (ra_hi_q[HALF-1] == rb_hi_q[HALF-1]) &&
                    (bus.add_sum[HALF-1] != ra_hi_q[HALF-1]);

`ifdef ADDSUB_SAT_EN
  assign fin_sum = raw_v ? (ra_hi_q[HALF-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : raw_sum;
`else
  assign fin_sum = raw_sum;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_hi_q     <= '0;
      rb_hi_q     <= '0;
      lo_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_c0_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_hi_q     <= ra_hi_d;
      rb_hi_q     <= rb_hi_d;
      lo_q        <= lo_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c0_q    <= add_c0_d;
    end
  end

  // Adder-slice drive is registered one state ahead; add_c0_q holds sub in LO and the mid carry in HI.
  always_comb begin
    state_d     = state_q;
    ra_hi_d     = ra_hi_q;
    rb_hi_d     = rb_hi_q;
    lo_d        = lo_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    add_a_d     = '0;
    add_b_d     = '0;
    add_c0_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          ra_hi_d    = bus.op_a[WIDTH-1:HALF];
          rb_hi_d    = op_b_eff[WIDTH-1:HALF];
          add_a_d    = bus.op_a[HALF-1:0];
          add_b_d    = op_b_eff[HALF-1:0];
          add_c0_d   = bus.sub;
          in_ready_d = 1'b0;
          state_d    = LO;
        end
      end
      LO: begin
        lo_d     = bus.add_sum;
        add_a_d  = ra_hi_q;
        add_b_d  = rb_hi_q;
        add_c0_d = bus.add_c16;
        state_d  = HI;
      end
      HI: begin
        result_d    = fin_sum;
        flag_n_d    = fin_sum[WIDTH-1];
        flag_z_d    = (fin_sum == '0);
        flag_c_d    = bus.add_c16;
        flag_v_d    = raw_v;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_v    = flag_v_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_c0    = add_c0_q;
endmodule

// File: tb/tb_alu32_addsub_seq.sv
// Directed bench for alu32_addsub_seq with a behavioural 16-bit adder slice.
module tb_alu32_addsub_seq;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu32_addsub_seq_if bus();

  alu32_addsub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External 16-bit adder slice
  assign {bus.add_c16, bus.add_sum} = 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_c0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
  endtask

  task automatic check_out(input string tag, input logic [31:0] res, input logic [3:0] nzcv);
    check({tag, "_result"}, bus.result, res);
    check({tag, "_nzcv"}, 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'(nzcv));
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_consumed"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset_hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("reset_result", bus.result, 32'h0);
    check("reset_flags", 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'h0);
    check("reset_adder", 32'({bus.add_a, bus.add_b, bus.add_c0}), 32'h0);
    rst = 1'b0;
    tick();

    // Low-half carry into the high half, checking the slice drive per phase
    accept(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    check("lo_drive", 32'({bus.add_a, bus.add_b}), 32'hFFFF_0001);
    check("lo_c0_ready", 32'({bus.add_c0, bus.in_ready}), 32'b00);
    tick();
    check("hi_drive", 32'({bus.add_a, bus.add_b}), 32'h0000_0000);
    check("hi_c0", 32'(bus.add_c0), 32'd1);
    tick();
    check("carry_valid_at_3", 32'(bus.out_valid), 32'd1);
    check_out("carry", 32'h0001_0000, 4'b0000);
    check("done_adder_idle", 32'({bus.add_a, bus.add_b, bus.add_c0}), 32'h0);
    consume("carry");

    // Signed overflow
    accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("ovf");
`ifdef ADDSUB_SAT_EN
    check_out("ovf", 32'h7FFF_FFFF, 4'b0001);
`else
    check_out("ovf", 32'h8000_0000, 4'b1001);
`endif
    consume("ovf");

    accept(32'h0000_0005, 32'h0000_0005, 1'b1);
    wait_done("sub_eq");
    check_out("sub_eq", 32'h0000_0000, 4'b0110);
    consume("sub_eq");

    accept(32'h0000_0000, 32'h0000_0001, 1'b1);
    wait_done("sub_borrow");
    check_out("sub_borrow", 32'hFFFF_FFFF, 4'b1000);
    consume("sub_borrow");

    // Backpressure with spurious in_valid pulses
    accept(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done("bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.op_a     = 32'hDEAD_BEEF;
      tick();
      check("bp_hold_result", bus.result, 32'h2345_6789);
      check("bp_hold_hs", 32'({bus.out_valid, bus.in_ready}), 32'b10);
      check("bp_hold_flags", 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'h0);
    end
    bus.in_valid = 1'b0;
    consume("bp");
    tick();
    check("bp_no_accept", 32'(bus.in_ready), 32'd1);

    // Reset while in HI discards the in-flight result
    accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_hi_hs", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    check("rst_hi_result", bus.result, 32'h0);
    check("rst_hi_flags", 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'h0);
    tick();
    tick();
    check("rst_hi_no_valid", 32'(bus.out_valid), 32'd0);
    accept(32'h0000_0001, 32'h0000_0002, 1'b0);
    wait_done("post_rst");
    check_out("post_rst", 32'h0000_0003, 4'b0000);
    consume("post_rst");

    // Operands changed after acceptance are ignored
    accept(32'h0000_0001, 32'h0000_0001, 1'b0);
    bus.op_a = 32'hFFFF_FFFF;
    bus.sub  = 1'b1;
    wait_done("late_op");
    check_out("late_op", 32'h0000_0002, 4'b0000);
    consume("late_op");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
